hc8_dma: RTL and testbench
==========================

# hc8_dma

Single-channel bus-master DMA engine for the HC8 system bus. It takes the bus from the HC8 core through `nDMA_REQ`, then drives `address_bus`, `data_bus`, `nRAM_RD` and `nRAM_WR` itself to run a block copy or a block fill. When the transfer ends it releases the bus. It is the requesting side of the core's DMA hold interface and shares the core's tristate bus and RAM strobes.

## Interface
- `GRANT_WAIT`, default 2: clk cycles spent in REQ with `nDMA_REQ` low before the first bus cycle. Covers the core's negedge sampling of `nDMA_REQ`. Minimum 1.
- `clk` input 1: system clock. All state changes on posedge.
- `nReset` input 1: reset, synchronous and active-low. Sampled on posedge `clk`.
- `start` input 1: launch request. Sampled only in IDLE.
- `mode` input 1: 0 = copy (read src, write dst); 1 = fill (write `fill_data` to dst).
- `src_addr` input 16: first source byte address. Ignored in fill mode.
- `dst_addr` input 16: first destination byte address.
- `length` input 16: byte count, 0..65535.
- `fill_data` input 8: fill byte.
- `nDMA_REQ` output 1: bus hold request to the core, active-low.
- `address_bus` output 16: tristate. Driven only in READ/WRITE.
- `data_bus` inout 8: driven only in WRITE. High-Z otherwise.
- `nRAM_RD` output 1: tristate read strobe, active-low. Driven only in READ/WRITE.
- `nRAM_WR` output 1: tristate write strobe, active-low. Driven only in READ/WRITE.
- `busy` output 1: high in REQ/READ/WRITE.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, REQ, READ, WRITE, DONE.
- The sequencer captures `mode`, `src_addr`, `dst_addr`, `length` and `fill_data` when `start` is accepted. Later changes to these inputs have no effect on the running transfer.
- IDLE:
  - `start`=1 with `length`≠0 → REQ. Wait counter loads `GRANT_WAIT`.
  - `start`=1 with `length`=0 → DONE. The bus is never requested.
- REQ: `nDMA_REQ`=0, all bus outputs high-Z. After `GRANT_WAIT` cycles → READ in copy mode, WRITE in fill mode.
- READ:
  - `address_bus`=src, `nRAM_RD`=0, `nRAM_WR`=1, `data_bus` high-Z.
  - At the closing posedge, `data_bus` latches into an 8-bit buffer → WRITE.
- WRITE:
  - `address_bus`=dst, `data_bus`=buffer (copy) or `fill_data` (fill), `nRAM_WR`=0, `nRAM_RD`=1.
  - At the closing posedge: src+=1, dst+=1, remaining-=1.
  - If remaining was 1 → DONE. Otherwise → READ (copy) or WRITE (fill).
- DONE: `done`=1, `busy`=0, `nDMA_REQ`=1, all bus outputs high-Z → IDLE.
- Address arithmetic is modulo 2^16: 0xFFFF+1 = 0x0000. Source and destination wrap independently.
- Copy runs forward, byte by byte. Overlapping ranges follow that order: dst<src is a correct move; dst>src replicates bytes.
- `start` outside IDLE is ignored. It is neither queued nor able to restart the transfer.

## Timing
- Reset values, taking effect at the first posedge with `nReset`=0:
  - state IDLE
  - `nDMA_REQ`=1, `busy`=0, `done`=0
  - `address_bus`, `data_bus`, `nRAM_RD`, `nRAM_WR` all high-Z
  - buffer and counters cleared
- Reset mid-transfer: the same reset values apply at that posedge. The bus is released immediately and no further strobe is issued.
- Cycle numbering: `start` sampled at posedge 0.
  - Cycles 1..`GRANT_WAIT` are REQ.
  - The first bus cycle is cycle `GRANT_WAIT`+1.
- Copy of N bytes takes 2N bus cycles. Fill of N bytes takes N bus cycles.
- `done` is asserted in the cycle after the last WRITE. `busy` falls in the same cycle that `done` rises.
- The drivers go high-Z at the same posedge that `nDMA_REQ` rises. The core regains the bus no earlier than the following negedge, so the drivers never overlap.
- Strobes are held low for the whole READ/WRITE cycle. The RAM must present read data before the closing posedge.
- Between consecutive bus cycles, `nRAM_RD` and `nRAM_WR` are never both low.

## Test plan
- Copy 3 bytes, src 0x0010 holding 11 22 33, dst 0x0020, `GRANT_WAIT`=2:
  - `nDMA_REQ` low cycles 1–8.
  - Reads at cycles 3, 5, 7; writes at cycles 4, 6, 8.
  - `done` at cycle 9.
  - RAM[0x20..0x22] = 11 22 33.
- Fill 4 bytes 0xA5 at dst 0x00FE: writes to 0x00FE, 0x00FF, 0x0100, 0x0101 on cycles 3–6. `done` at cycle 7. `nRAM_RD` stays 1 throughout.
- Length 0: `done` at cycle 1, `nDMA_REQ` never low, bus stays high-Z.
- Copy 2 bytes with src 0xFFFF and dst 0xFFFE: reads from 0xFFFF then 0x0000; writes to 0xFFFE then 0xFFFF.
- Reset mid-transfer: `nReset`=0 during the second WRITE of a 4-byte fill.
  - At the next posedge: bus high-Z, `nDMA_REQ`=1, `busy`=0, and `done` is not pulsed.
  - Only 1 byte has been written.
- `start` pulsed with new parameters while `busy`=1: it is ignored. The original transfer completes unchanged, and there is exactly one `done` pulse.

Source files
------------

// File: rtl/hc8_dma.sv
// hc8_dma: single-channel bus-master DMA for the HC8 system bus.
// Requests the bus with nDMA_REQ, waits GRANT_WAIT cycles, then runs a
// byte-wise block copy (READ/WRITE pairs) or block fill (WRITE only), and
// releases every bus driver in the DONE cycle.
module hc8_dma #(
  parameter int unsigned GRANT_WAIT = 2
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  input  logic [7:0]  fill_data,
  output logic        nDMA_REQ,
  output logic [15:0] address_bus,
  inout  logic [7:0]  data_bus,
  output logic        nRAM_RD,
  output logic        nRAM_WR,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic        mode_q, mode_d;
  logic [7:0]  fill_q, fill_d;
  logic [7:0]  buf_q, buf_d;

  logic        drive_bus;
  logic        in_read;
  logic        in_write;

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= 1'b0;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and datapath update; parameters are captured only on accepted start
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = length;
          fill_d  = fill_data;
          wait_d  = 16'(GRANT_WAIT);
          state_d = (length != '0) ? ST_REQ : ST_DONE;
        end
      end
      ST_REQ: begin
        if (wait_q <= 16'd1) begin
          state_d = mode_q ? ST_WRITE : ST_READ;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      ST_READ: begin
        buf_d   = data_bus;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        src_d   = src_q + 16'd1;
        dst_d   = dst_q + 16'd1;
        rem_d   = rem_q - 16'd1;
        if (rem_q == 16'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = mode_q ? ST_WRITE : ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus ownership decode: all drivers are released outside READ/WRITE
  always_comb begin
    in_read   = (state_q == ST_READ);
    in_write  = (state_q == ST_WRITE);
    drive_bus = in_read || in_write;
    busy      = (state_q == ST_REQ) || drive_bus;
    nDMA_REQ  = !busy;
    done      = (state_q == ST_DONE);
  end

  assign address_bus = drive_bus ? (in_read ? src_q : dst_q) : 'z;
  assign nRAM_RD     = drive_bus ? !in_read : 1'bz;
  assign nRAM_WR     = drive_bus ? !in_write : 1'bz;
  assign data_bus    = in_write ? (mode_q ? fill_q : buf_q) : 'z;

endmodule

// File: tb/tb_hc8_dma.sv
// tb_hc8_dma: directed and randomized transfers against a byte-level
// reference memory; every cycle of each transfer is compared with the
// expected bus activity derived from the transfer parameters.
module tb_hc8_dma;

  localparam int unsigned GW = 2;

  logic        clk = 1'b0;
  logic        nReset;
  logic        start;
  logic        mode;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic [7:0]  fill_data;
  wire         nDMA_REQ;
  wire  [15:0] address_bus;
  wire  [7:0]  data_bus;
  wire         nRAM_RD;
  wire         nRAM_WR;
  wire         busy;
  wire         done;

  // Released bus lines float high so a driver left on is visible
  pullup (address_bus);
  pullup (data_bus);
  pullup (nRAM_RD);
  pullup (nRAM_WR);

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  hc8_dma #(.GRANT_WAIT(GW)) dut (
    .clk        (clk),
    .nReset     (nReset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_data  (fill_data),
    .nDMA_REQ   (nDMA_REQ),
    .address_bus(address_bus),
    .data_bus   (data_bus),
    .nRAM_RD    (nRAM_RD),
    .nRAM_WR    (nRAM_WR),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // RAM read port: drives the data bus while the read strobe is low
  assign data_bus = (nRAM_RD == 1'b0) ? ram[address_bus] : 'z;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_req"},  32'(nDMA_REQ), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd"},   32'(nRAM_RD), 32'd1);
    chk({tag, "_wr"},   32'(nRAM_WR), 32'd1);
    chk({tag, "_addr"}, 32'(address_bus), 32'hFFFF);
    chk({tag, "_data"}, 32'(data_bus), 32'hFF);
  endtask

  // One transfer from start to the first idle cycle after completion.
  // poke: re-pulse start with fresh parameters while the transfer runs.
  // rst_cyc: cycle during which nReset is held low (0 = none).
  task automatic run_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] len, input logic [7:0] f,
                          input bit poke, input int rst_cyc);
    int         r, nb, last, j, exp_wr_cnt, seen_wr;
    logic [7:0] v;
    logic       e_req, e_busy, e_done, e_rd, e_wr, is_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    r    = (len == 16'd0) ? 0 : int'(GW);
    nb   = (len == 16'd0) ? 0 : (m ? int'(len) : 2 * int'(len));
    last = (rst_cyc > 0) ? rst_cyc + 2 : r + nb + 2;
    v = '0;
    exp_wr_cnt = 0;
    seen_wr = 0;
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = len; fill_data = f; start = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      start     = 1'b0;
      mode      = 1'($urandom);
      src_addr  = 16'($urandom);
      dst_addr  = 16'($urandom);
      length    = 16'($urandom_range(1, 9));
      fill_data = 8'($urandom);
      e_req = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b1; e_wr = 1'b1;
      e_addr = '1; e_data = '1; is_wr = 1'b0;
      if (rst_cyc > 0 && k > rst_cyc) begin
        e_req = 1'b1;
      end else if (k <= r) begin
        e_req = 1'b0; e_busy = 1'b1;
      end else if (k <= r + nb) begin
        e_req = 1'b0; e_busy = 1'b1;
        j = k - r - 1;
        if (m) begin
          e_wr = 1'b0; e_addr = d + 16'(j); e_data = f; is_wr = 1'b1;
        end else if (j % 2 == 0) begin
          e_rd = 1'b0; e_addr = s + 16'(j / 2); v = ref_mem[e_addr]; e_data = v;
        end else begin
          e_wr = 1'b0; e_addr = d + 16'(j / 2); e_data = v; is_wr = 1'b1;
        end
      end else if (k == r + nb + 1) begin
        e_done = 1'b1;
      end
      chk("nDMA_REQ", 32'(nDMA_REQ), 32'(e_req));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("nRAM_RD", 32'(nRAM_RD), 32'(e_rd));
      chk("nRAM_WR", 32'(nRAM_WR), 32'(e_wr));
      chk("address_bus", 32'(address_bus), 32'(e_addr));
      chk("data_bus", 32'(data_bus), 32'(e_data));
      nReset = !(rst_cyc > 0 && k == rst_cyc);
      if (nReset && is_wr) begin
        ref_mem[e_addr] = e_data;
        exp_wr_cnt++;
      end
      if (nReset && nRAM_WR == 1'b0) begin
        ram[address_bus] = data_bus;
        seen_wr++;
      end
      if (poke && (k == 1 || k == r + 1 || k == r + nb + 1)) begin
        start = 1'b1;
        mode  = ~m;
      end
    end
    chk("write_count", 32'(seen_wr), 32'(exp_wr_cnt));
    for (int i = 0; i < int'(len) && i < 16; i++) begin
      chk("ram_dst", 32'(ram[d + 16'(i)]), 32'(ref_mem[d + 16'(i)]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pre;
    logic        m;
    logic [15:0] s, d, len;
    for (int i = 0; i < 65536; i++) set_mem(16'(i), 8'($urandom));
    nReset = 1'b0; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_data = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    nReset = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Copy 3 bytes 0x0010 -> 0x0020
    set_mem(16'h0010, 8'h11); set_mem(16'h0011, 8'h22); set_mem(16'h0012, 8'h33);
    run_xfer(1'b0, 16'h0010, 16'h0020, 16'd3, 8'h00, 1'b0, 0);
    chk("copy3_b0", 32'(ram[16'h0020]), 32'h11);
    chk("copy3_b1", 32'(ram[16'h0021]), 32'h22);
    chk("copy3_b2", 32'(ram[16'h0022]), 32'h33);

    // Fill 4 bytes of 0xA5 across a page boundary
    run_xfer(1'b1, 16'h1234, 16'h00FE, 16'd4, 8'hA5, 1'b0, 0);
    chk("fill_fe",  32'(ram[16'h00FE]), 32'hA5);
    chk("fill_101", 32'(ram[16'h0101]), 32'hA5);

    // Zero length: immediate done, bus never requested
    run_xfer(1'b0, 16'h4000, 16'h5000, 16'd0, 8'h00, 1'b0, 0);

    // Copy across the top of the address space
    set_mem(16'hFFFF, 8'h5A); set_mem(16'h0000, 8'hC3);
    run_xfer(1'b0, 16'hFFFF, 16'hFFFE, 16'd2, 8'h00, 1'b0, 0);
    chk("wrap_fffe", 32'(ram[16'hFFFE]), 32'h5A);
    chk("wrap_ffff", 32'(ram[16'hFFFF]), 32'hC3);

    // Reset during the second write of a 4-byte fill
    set_mem(16'h3001, 8'h3C);
    pre = ram[16'h3001];
    run_xfer(1'b1, 16'h0000, 16'h3000, 16'd4, 8'h77, 1'b0, int'(GW) + 2);
    chk("rst_b0", 32'(ram[16'h3000]), 32'h77);
    chk("rst_b1", 32'(ram[16'h3001]), 32'(pre));

    // start re-pulsed while busy and in DONE
    run_xfer(1'b0, 16'h0200, 16'h0300, 16'd3, 8'h00, 1'b1, 0);

    // Overlapping copies in both directions
    run_xfer(1'b0, 16'h0400, 16'h0402, 16'd6, 8'h00, 1'b0, 0);
    run_xfer(1'b0, 16'h0502, 16'h0500, 16'd6, 8'h00, 1'b0, 0);

    // Randomized transfers, some overlapping, some fills, some empty
    for (int t = 0; t < 24; t++) begin
      m   = 1'($urandom);
      s   = 16'($urandom);
      d   = ($urandom_range(0, 2) == 0) ? s + 16'($urandom_range(0, 6)) - 16'd3 : 16'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 9));
      run_xfer(m, s, d, len, 8'($urandom), ($urandom_range(0, 3) == 0), 0);
    end

    @(negedge clk);
    check_idle("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
